// File: rtl/checkout_tally.sv
// Checkout-lane tally: synchronizes the scan/clear buttons and checker flags,
// counts scanned and discounted items, and latches a blinking theft alarm.
module checkout_tally #(
    parameter int MAX_ITEMS    = 15,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan,
    input  logic       clear,
    input  logic       discount,
    input  logic       stolen,
    output logic [3:0] item_count,
    output logic [3:0] disc_count,
    output logic       full,
    output logic       alarm,
    output logic       alarm_blink
);

    localparam int            CW         = $clog2(BLINK_CYCLES);
    localparam logic [3:0]    MAX_C      = 4'(MAX_ITEMS);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ALARM = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    scan_sync_q, clear_sync_q;
    logic [1:0]    disc_sync_q, stolen_sync_q;
    logic [3:0]    item_q, item_d;
    logic [3:0]    disc_q, disc_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    logic scan_p, clear_p, disc_s, stolen_s;

    // Flags come off the 2nd flop so they line up with the edge-detect pulses.
    assign scan_p   = scan_sync_q[1] & ~scan_sync_q[2];
    assign clear_p  = clear_sync_q[1] & ~clear_sync_q[2];
    assign disc_s   = disc_sync_q[1];
    assign stolen_s = stolen_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_sync_q   <= '0;
            clear_sync_q  <= '0;
            disc_sync_q   <= '0;
            stolen_sync_q <= '0;
            state_q       <= ST_IDLE;
            item_q        <= '0;
            disc_q        <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
        end else begin
            scan_sync_q   <= {scan_sync_q[1:0], scan};
            clear_sync_q  <= {clear_sync_q[1:0], clear};
            disc_sync_q   <= {disc_sync_q[0], discount};
            stolen_sync_q <= {stolen_sync_q[0], stolen};
            state_q       <= state_d;
            item_q        <= item_d;
            disc_q        <= disc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!clear_p && scan_p && stolen_s) state_d = ST_ALARM;
            ST_ALARM: if (clear_p) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Clear beats scan; a stolen item still occupies a slot but never earns a discount.
    always_comb begin
        item_d = item_q;
        disc_d = disc_q;
        if (state_q == ST_IDLE) begin
            if (clear_p) begin
                item_d = '0;
                disc_d = '0;
            end else if (scan_p && (item_q < MAX_C)) begin
                item_d = item_q + 4'd1;
                if (disc_s && !stolen_s) disc_d = disc_q + 4'd1;
            end
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == ST_ALARM) begin
            if (state_q == ST_IDLE) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CW'(1);
                blink_d     = blink_q;
            end
        end
    end

    always_comb begin
        item_count  = item_q;
        disc_count  = disc_q;
        full        = (item_q == MAX_C);
        alarm       = (state_q == ST_ALARM);
        alarm_blink = blink_q;
    end

endmodule

// File: tb/tb_checkout_tally.sv
// Directed bench for checkout_tally with MAX_ITEMS=3 and BLINK_CYCLES=4.
module tb_checkout_tally;

    logic       clk = 1'b0;
    logic       reset, scan, clear, discount, stolen;
    logic [3:0] item_count, disc_count;
    logic       full, alarm, alarm_blink;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];

    localparam logic [1:0] OP_SCAN  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;

    typedef struct {
        logic [1:0] op;
        logic       disc;
        logic       stol;
        logic [3:0] e_item;
        logic [3:0] e_disc;
        logic       e_full;
        logic       e_alarm;
    } vec_t;

    vec_t vecs[18];

    checkout_tally #(.MAX_ITEMS(3), .BLINK_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan       (scan),
        .clear      (clear),
        .discount   (discount),
        .stolen     (stolen),
        .item_count (item_count),
        .disc_count (disc_count),
        .full       (full),
        .alarm      (alarm),
        .alarm_blink(alarm_blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press(input logic sc, input logic cl, input logic d, input logic s);
        @(negedge clk);
        scan = sc; clear = cl; discount = d; stolen = s;
        repeat (5) @(negedge clk);
        scan = 1'b0; clear = 1'b0; discount = 1'b0; stolen = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic d, input logic s,
                           input logic [3:0] ei, input logic [3:0] ed, input logic ef,
                           input logic ea);
        vecs[i].op = op; vecs[i].disc = d; vecs[i].stol = s;
        vecs[i].e_item = ei; vecs[i].e_disc = ed; vecs[i].e_full = ef; vecs[i].e_alarm = ea;
    endtask

    initial begin
        logic [9:0] e;
        reset = 1'b0; scan = 1'b0; clear = 1'b0; discount = 1'b0; stolen = 1'b0;

        set_vec(0,  OP_SCAN,  1, 0, 1, 1, 0, 0);
        set_vec(1,  OP_SCAN,  1, 0, 2, 2, 0, 0);
        set_vec(2,  OP_SCAN,  1, 0, 3, 3, 1, 0);
        set_vec(3,  OP_CLEAR, 0, 0, 0, 0, 0, 0);
        set_vec(4,  OP_SCAN,  0, 0, 1, 0, 0, 0);
        set_vec(5,  OP_SCAN,  0, 0, 2, 0, 0, 0);
        set_vec(6,  OP_SCAN,  0, 0, 3, 0, 1, 0);
        set_vec(7,  OP_SCAN,  0, 0, 3, 0, 1, 0);
        set_vec(8,  OP_SCAN,  1, 0, 3, 0, 1, 0);
        set_vec(9,  OP_CLEAR, 0, 0, 0, 0, 0, 0);
        set_vec(10, OP_SCAN,  0, 0, 1, 0, 0, 0);
        set_vec(11, OP_SCAN,  1, 0, 2, 1, 0, 0);
        set_vec(12, OP_SCAN,  1, 1, 3, 1, 1, 1);
        set_vec(13, OP_SCAN,  1, 0, 3, 1, 1, 1);
        set_vec(14, OP_CLEAR, 0, 0, 3, 1, 1, 0);
        set_vec(15, OP_SCAN,  1, 1, 3, 1, 1, 1);
        set_vec(16, OP_CLEAR, 0, 0, 3, 1, 1, 0);
        set_vec(17, OP_CLEAR, 0, 0, 0, 0, 0, 0);

        do_reset();
        @(negedge clk);
        check("rst_item", item_count, 0);
        check("rst_disc", disc_count, 0);
        check("rst_full", full, 0);
        check("rst_alarm", alarm, 0);
        check("rst_blink", alarm_blink, 0);

        for (int i = 0; i < 18; i++) begin
            exp_q.push_back({vecs[i].e_item, vecs[i].e_disc, vecs[i].e_full, vecs[i].e_alarm});
            if (vecs[i].op == OP_SCAN) press(1'b1, 1'b0, vecs[i].disc, vecs[i].stol);
            else                       press(1'b0, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            check($sformatf("v%0d_item", i), item_count, e[9:6]);
            check($sformatf("v%0d_disc", i), disc_count, e[5:2]);
            check($sformatf("v%0d_full", i), full, e[1]);
            check($sformatf("v%0d_alarm", i), alarm, e[0]);
            if (!e[0]) check($sformatf("v%0d_blink", i), alarm_blink, 0);
        end

        // Two-edge latency, then a long hold yields a single increment.
        do_reset();
        @(negedge clk);
        scan = 1'b1; discount = 1'b1;
        @(negedge clk); check("lat_k", item_count, 0);
        @(negedge clk); check("lat_k1", item_count, 0);
        @(negedge clk); check("lat_k2", item_count, 1);
        check("lat_k2_disc", disc_count, 1);
        repeat (47) @(negedge clk);
        check("hold_item", item_count, 1);
        scan = 1'b0; discount = 1'b0;
        repeat (5) @(negedge clk);

        // Scan and clear together in IDLE with two items.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_sim_item", item_count, 2);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check("sim_idle_item", item_count, 0);
        check("sim_idle_disc", disc_count, 0);

        // Blink waveform: alarm entered at edge k+2, then 4 high / 4 low.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        scan = 1'b1; stolen = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("blink_pre_alarm", alarm, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), alarm_blink, ((i / 4) % 2 == 0) ? 1 : 0);
            check($sformatf("blink_alarm_%0d", i), alarm, 1);
        end
        scan = 1'b0; stolen = 1'b0;
        repeat (5) @(negedge clk);
        check("alarm_item", item_count, 2);
        check("alarm_disc", disc_count, 0);

        // Scan and clear together in ALARM: acknowledge only, scan dropped.
        press(1'b1, 1'b1, 1'b1, 1'b0);
        check("sim_alarm_alarm", alarm, 0);
        check("sim_alarm_blink", alarm_blink, 0);
        check("sim_alarm_item", item_count, 2);
        check("sim_alarm_disc", disc_count, 0);

        // Reset while alarmed, then a scan counts from zero.
        press(1'b1, 1'b0, 1'b1, 1'b1);
        check("pre_rst_alarm", alarm, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_alarm", alarm, 0);
        check("mid_rst_blink", alarm_blink, 0);
        check("mid_rst_item", item_count, 0);
        check("mid_rst_disc", disc_count, 0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_item", item_count, 1);
        check("post_rst_alarm", alarm, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
